// File: rtl/lsu_pkg.sv
// Shared types and constants for the warp load/store unit.
package lsu_pkg;

  localparam int LANES      = 8;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  // Registers at or above this index are read-only to the LSU.
  localparam logic [REG_ADDR_W-1:0] RO_REG_BASE = REG_ADDR_W'(13);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } lsu_state_t;

  function automatic logic is_ro_reg(input logic [REG_ADDR_W-1:0] reg_idx);
    return (reg_idx >= RO_REG_BASE);
  endfunction

endpackage

// File: rtl/lsu_lane_buffer.sv
// Per-lane load result buffer: indexed single-lane write, whole-buffer clear.
module lsu_lane_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8,
  localparam int IDX_W     = $clog2(LANES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [LANES-1:0][DATA_WIDTH-1:0] rd_data
);

  logic [LANES-1:0][DATA_WIDTH-1:0] lane_buf_r;

  // Result storage; clear wins over a write in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_buf_r <= '0;
    end else if (clear) begin
      lane_buf_r <= '0;
    end else if (wr_en) begin
      lane_buf_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = lane_buf_r;

endmodule

// File: rtl/warp_lsu.sv
// Per-warp load/store unit: serialises eight lanes onto one memory port and
// writes load results back in a single cycle. Optional: LSU_LANE_MASK_EN.
module warp_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = lsu_pkg::LANES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             is_store,
  input  logic [1:0]                       warp_num,
  input  logic [REG_ADDR_W-1:0]            dest_reg,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] lane_addr,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] lane_wdata,
  input  logic [LANES-1:0]                 lane_mask,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [DATA_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_wdata,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  output logic                             reg_write_en,
  output logic [REG_ADDR_W-1:0]            reg_write_addr,
  output logic [LANES-1:0][DATA_WIDTH-1:0] reg_write_data,
  output logic [1:0]                       warp_num_write,
  output logic                             busy,
  output logic                             done,
  output logic                             ro_err
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  lsu_state_t state_r, state_n;
  logic [CNT_W-1:0] k_r, k_n, next_k_s;

  logic [LANES-1:0][DATA_WIDTH-1:0] addr_r, wdata_r;
  logic [LANES-1:0]      mask_r, start_mask_s;
  logic                  is_store_r;
  logic [REG_ADDR_W-1:0] dest_r;
  logic [1:0]            warp_r;
  logic                  latch_s, advance_s, ro_s;

  logic                  req_valid_r, req_valid_n, req_we_r, req_we_n;
  logic [DATA_WIDTH-1:0] req_addr_r, req_addr_n, req_wdata_r, req_wdata_n;
  logic                  wr_en_r, wr_en_n, ro_err_r, ro_err_n;
  logic                  done_r, done_n, busy_r, busy_n;

  logic                  buf_clear_s, buf_we_s;
  logic [DATA_WIDTH-1:0] buf_wdata_s;
  logic [LANES-1:0][DATA_WIDTH-1:0] buf_data_s;

`ifdef LSU_LANE_MASK_EN
  assign start_mask_s = lane_mask;
`else
  // Every lane active; the mask input has no effect in this build.
  assign start_mask_s = lane_mask | {LANES{1'b1}};
`endif

  assign next_k_s = k_r + CNT_W'(1);
  assign ro_s     = is_ro_reg(dest_r);

  // Next-state and next-output logic; request fields hold unless reloaded.
  always_comb begin
    state_n     = state_r;
    k_n         = k_r;
    latch_s     = 1'b0;
    advance_s   = 1'b0;
    req_valid_n = 1'b0;
    req_we_n    = 1'b0;
    req_addr_n  = req_addr_r;
    req_wdata_n = req_wdata_r;
    wr_en_n     = 1'b0;
    ro_err_n    = 1'b0;
    done_n      = 1'b0;
    buf_clear_s = 1'b0;
    buf_we_s    = 1'b0;
    buf_wdata_s = '0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          latch_s     = 1'b1;
          buf_clear_s = 1'b1;
          k_n         = '0;
          state_n     = ST_REQ;
          req_valid_n = start_mask_s[0];
          req_we_n    = is_store & start_mask_s[0];
          req_addr_n  = lane_addr[0];
          req_wdata_n = lane_wdata[0];
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_valid_r && !mem_req_ready) begin
          req_valid_n = 1'b1;
          req_we_n    = req_we_r;
        end else if (req_valid_r && !is_store_r) begin
          state_n = ST_WAIT;
        end else begin
          // Store handshake, or an inactive lane that only zeroes its slot.
          advance_s   = 1'b1;
          buf_we_s    = ~req_valid_r;
          buf_wdata_s = '0;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          advance_s   = 1'b1;
          buf_we_s    = 1'b1;
          buf_wdata_s = mem_rsp_data;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_WB: begin
        state_n = ST_DONE;
        done_n  = 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (advance_s) begin
      if (k_r == LAST_LANE) begin
        if (is_store_r) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          state_n  = ST_WB;
          wr_en_n  = ~ro_s;
          ro_err_n = ro_s;
        end
      end else begin
        k_n         = next_k_s;
        state_n     = ST_REQ;
        req_valid_n = mask_r[next_k_s];
        req_we_n    = is_store_r & mask_r[next_k_s];
        req_addr_n  = addr_r[next_k_s];
        req_wdata_n = wdata_r[next_k_s];
      end
    end else begin
      k_n = k_n;
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State, lane counter, latched operands and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      k_r         <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      mask_r      <= '0;
      is_store_r  <= 1'b0;
      dest_r      <= '0;
      warp_r      <= 2'd0;
      req_valid_r <= 1'b0;
      req_we_r    <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= '0;
      wr_en_r     <= 1'b0;
      ro_err_r    <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      k_r         <= k_n;
      req_valid_r <= req_valid_n;
      req_we_r    <= req_we_n;
      req_addr_r  <= req_addr_n;
      req_wdata_r <= req_wdata_n;
      wr_en_r     <= wr_en_n;
      ro_err_r    <= ro_err_n;
      done_r      <= done_n;
      busy_r      <= busy_n;
      if (latch_s) begin
        addr_r     <= lane_addr;
        wdata_r    <= lane_wdata;
        mask_r     <= start_mask_s;
        is_store_r <= is_store;
        dest_r     <= dest_reg;
        warp_r     <= warp_num;
      end
    end
  end

  lsu_lane_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_lane_buffer (
    .clk     (clk),
    .reset   (reset),
    .clear   (buf_clear_s),
    .wr_en   (buf_we_s),
    .wr_idx  (k_r),
    .wr_data (buf_wdata_s),
    .rd_data (buf_data_s)
  );

  assign mem_req_valid  = req_valid_r;
  assign mem_req_we     = req_we_r;
  assign mem_req_addr   = req_addr_r;
  assign mem_req_wdata  = req_wdata_r;
  assign reg_write_en   = wr_en_r;
  assign reg_write_addr = dest_r;
  assign reg_write_data = buf_data_s;
  assign warp_num_write = warp_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign ro_err         = ro_err_r;

endmodule

// File: tb/tb_warp_lsu.sv
// Scoreboard bench for warp_lsu: stimulus queues expected memory requests and
// write-backs; a monitor compares them as the DUT presents them.
module tb_warp_lsu;

  localparam int DW = 16;
  localparam int LN = 8;
`ifdef LSU_LANE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [3:0]       addr;
    logic [1:0]       warp;
    logic [LN*DW-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic reset, start, is_store;
  logic [1:0] warp_num;
  logic [3:0] dest_reg;
  logic [LN-1:0][DW-1:0] lane_addr, lane_wdata;
  logic [LN-1:0] lane_mask;
  logic mem_req_valid, mem_req_ready, mem_req_we;
  logic [DW-1:0] mem_req_addr, mem_req_wdata;
  logic mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic reg_write_en;
  logic [3:0] reg_write_addr;
  logic [LN-1:0][DW-1:0] reg_write_data;
  logic [1:0] warp_num_write;
  logic busy, done, ro_err;

  req_t req_q[$];
  wb_t  wb_q[$];
  bit   ro_q[$];
  bit   done_q[$];

  int n_pass = 0;
  int n_total = 0;
  int stall_left = 0;
  logic [DW-1:0] stall_addr = 16'h0000;

  always #5 clk = ~clk;

  warp_lsu dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .warp_num(warp_num), .dest_reg(dest_reg), .lane_addr(lane_addr),
    .lane_wdata(lane_wdata), .lane_mask(lane_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .reg_write_en(reg_write_en),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .warp_num_write(warp_num_write), .busy(busy), .done(done), .ro_err(ro_err)
  );

  task automatic check(input string name, input logic [LN*DW-1:0] act, input logic [LN*DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: zero-wait unless stalling a chosen address; load data = addr + 0x100.
  initial begin
    bit hs_prev;
    logic [DW-1:0] prev_addr;
    hs_prev = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rsp_valid = 1'b0;
      if (hs_prev && !reset) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = prev_addr + 16'h0100;
      end
      if (mem_req_valid && stall_left > 0 && mem_req_addr == stall_addr) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      hs_prev   = mem_req_valid && mem_req_ready && !mem_req_we && !reset;
      prev_addr = mem_req_addr;
    end
  end

  // Monitor: compares every presented request and write-back with the queue heads.
  initial begin
    req_t r;
    wb_t  w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req_valid) begin
          check("req_expected", req_q.size() > 0, 1'b1);
          if (req_q.size() > 0) begin
            r = req_q[0];
            check("req_we", mem_req_we, r.we);
            check("req_addr", mem_req_addr, r.addr);
            check("req_wdata", mem_req_wdata, r.wdata);
            if (mem_req_ready) void'(req_q.pop_front());
          end
        end
        if (reg_write_en) begin
          check("wb_expected", wb_q.size() > 0, 1'b1);
          if (wb_q.size() > 0) begin
            w = wb_q.pop_front();
            check("wb_addr", reg_write_addr, w.addr);
            check("wb_warp", warp_num_write, w.warp);
            check("wb_data", reg_write_data, w.data);
          end
        end
        if (ro_err) begin
          check("ro_err_expected", ro_q.size() > 0, 1'b1);
          if (ro_q.size() > 0) void'(ro_q.pop_front());
        end
        if (done) begin
          check("done_expected", done_q.size() > 0, 1'b1);
          if (done_q.size() > 0) void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [1:0] w, input logic [3:0] d,
                       input logic [DW-1:0] abase, input logic [DW-1:0] dbase, input logic [LN-1:0] m);
    wb_t  e;
    req_t r;
    bit   act;
    e.addr = d;
    e.warp = w;
    e.data = '0;
    for (int k = 0; k < LN; k++) begin
      act = MASK_EN ? m[k] : 1'b1;
      if (act) begin
        r.we = st;
        r.addr = abase + DW'(k);
        r.wdata = dbase + DW'(k);
        req_q.push_back(r);
        e.data[k*DW +: DW] = abase + DW'(k) + 16'h0100;
      end
    end
    if (!st) begin
      if (d >= 4'd13) ro_q.push_back(1'b1);
      else wb_q.push_back(e);
    end
    done_q.push_back(1'b1);
    @(negedge clk);
    start = 1'b1; is_store = st; warp_num = w; dest_reg = d; lane_mask = m;
    for (int k = 0; k < LN; k++) begin
      lane_addr[k]  = abase + DW'(k);
      lane_wdata[k] = dbase + DW'(k);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int  c;
    bit  seen;
    seen = 1'b0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1'b1);
    if (seen && exp_cycles > 0) check({name, "_latency"}, c, exp_cycles);
    @(negedge clk);
    check({name, "_busy_clear"}, busy, 1'b0);
    check({name, "_queues_drained"}, req_q.size() + wb_q.size() + ro_q.size() + done_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; warp_num = 2'd0; dest_reg = 4'd0;
    lane_addr = '0; lane_wdata = '0; lane_mask = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {mem_req_valid, mem_req_we, reg_write_en, busy, done, ro_err}, 6'd0);
    check("reset_data", {mem_req_addr, mem_req_wdata, reg_write_addr, warp_num_write}, '0);
    check("reset_wb_data", reg_write_data, '0);
    @(posedge clk); #4 reset = 1'b0;

    issue(1'b0, 2'd2, 4'd5, 16'h0010, 16'h0000, 8'hFF);
    wait_done("load_basic", 18);

    stall_addr = 16'h0023; stall_left = 3;
    issue(1'b1, 2'd1, 4'd3, 16'h0020, 16'h00A0, 8'hFF);
    wait_done("store_stall", 12);

    issue(1'b0, 2'd3, 4'd14, 16'h0030, 16'h0050, 8'hFF);
    wait_done("load_ro", 18);

    issue(1'b0, 2'd1, 4'd7, 16'h0040, 16'h0060, 8'hFF);
    repeat (3) @(negedge clk);
    start = 1'b1; is_store = 1'b1; warp_num = 2'd3; dest_reg = 4'd9;
    for (int k = 0; k < LN; k++) lane_addr[k] = 16'h0070 + DW'(k);
    @(posedge clk); #1 start = 1'b0;
    wait_done("start_while_busy", 0);

    issue(1'b0, 2'd0, 4'd6, 16'h0080, 16'h0090, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready && mem_req_addr == 16'h0084) found = 1'b1;
    end
    check("lane4_handshake_seen", found, 1'b1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("midop_reset_ctrl", {mem_req_valid, mem_req_we, reg_write_en, busy, done, ro_err}, 6'd0);
    check("midop_reset_data", {mem_req_addr, mem_req_wdata, reg_write_addr, warp_num_write}, '0);
    check("midop_reset_wb_data", reg_write_data, '0);
    req_q.delete(); wb_q.delete(); ro_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    issue(1'b0, 2'd0, 4'd6, 16'h0088, 16'h0090, 8'hFF);
    wait_done("after_reset", 18);

    issue(1'b0, 2'd2, 4'd4, 16'h00C0, 16'h00D0, 8'hA5);
    wait_done("lane_mask", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
